// File: rtl/vga_sync_monitor.sv
// Passive VGA timing monitor: tracks hSync/vSync, locks onto clean timing, samples a probe pixel.
// Optional per-frame rgb checksum (frame_sum/sum_valid) is compiled in with VGA_MON_CHECKSUM_EN.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_PULSE     = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_PULSE     = 2,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515,
  parameter int PROBE_X     = 400,
  parameter int PROBE_Y     = 275
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  vgaR,
  input  logic [3:0]  vgaG,
  input  logic [3:0]  vgaB,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_cnt,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
`ifdef VGA_MON_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        sum_valid
`endif
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_PW   = 10'(H_PULSE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_PW   = 10'(V_PULSE);
  localparam logic [9:0] P_X    = 10'(PROBE_X);
  localparam logic [9:0] P_Y    = 10'(PROBE_Y);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  // Reject inconsistent timing parameters at elaboration.
  if (H_VIS_START >= H_VIS_END || H_VIS_END > H_TOTAL || V_VIS_START >= V_VIS_END ||
      V_VIS_END > V_TOTAL || PROBE_X >= H_TOTAL || PROBE_Y >= V_TOTAL ||
      H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
    $error("vga_sync_monitor: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        track_seen, track_seen_nxt;
  logic        hs_r, vs_r, hs_d, vs_d;
  logic [11:0] rgb_r;
  logic [1:0]  phase, phase_eff;
  logic [9:0]  hpos, hpos_cur, vline, vline_cur;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, tick;
  logic        h_viol, v_viol, viol, probe_hit;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      rgb_r <= '0;
    end else begin
      hs_r  <= hSync;
      vs_r  <= vSync;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      rgb_r <= {vgaR, vgaG, vgaB};
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign hs_rise = ~hs_d & hs_r;
  assign vs_fall = vs_d & ~vs_r;
  assign vs_rise = ~vs_d & vs_r;

  // *_cur is the position this cycle stands on: an hSync fall is itself tick 0 of the line.
  always_comb begin
    phase_eff = hs_fall ? 2'd0 : phase;
    tick      = (phase_eff == 2'd0);
    hpos_cur  = hpos;
    if (hs_fall)
      hpos_cur = '0;
    else if (tick && hpos != CNT_MAX)
      hpos_cur = hpos + 10'd1;
    vline_cur = vline;
    if (vs_fall)
      vline_cur = '0;
    else if (hs_fall && vline != CNT_MAX)
      vline_cur = vline + 10'd1;
  end

  // Falls close a line/frame and see the last position; rises mark the position being entered.
  always_comb begin
    h_viol = (state != SEARCH) &&
             ((hs_fall && hpos != H_LAST) || (hs_rise && hpos_cur != H_PW));
    v_viol = (state != SEARCH) &&
             ((vs_fall && vline != V_LAST) || (vs_rise && vline_cur != V_PW));
    viol      = h_viol | v_viol;
    probe_hit = (state == LOCKED) && tick && hpos_cur == P_X && vline_cur == P_Y;
  end

  always_comb begin
    state_nxt      = state;
    track_seen_nxt = track_seen;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt      = TRACK;
          track_seen_nxt = 1'b0;
        end
      end
      TRACK: begin
        if (viol)
          state_nxt = SEARCH;
        else if (vs_fall) begin
          if (track_seen)
            state_nxt = LOCKED;
          else
            track_seen_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (viol)
          state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state       <= SEARCH;
      track_seen  <= 1'b0;
      phase       <= '0;
      hpos        <= '0;
      vline       <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_cnt   <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      track_seen  <= track_seen_nxt;
      phase       <= phase_eff + 2'd1;
      hpos        <= hpos_cur;
      vline       <= vline_cur;
      h_err       <= h_err | h_viol;
      v_err       <= v_err | v_viol;
      probe_valid <= probe_hit;
      if (state == LOCKED && vs_fall && !viol)
        frame_cnt <= frame_cnt + 16'd1;
      if (probe_hit)
        probe_rgb <= rgb_r;
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_MON_CHECKSUM_EN
  localparam logic [9:0] HV_S = 10'(H_VIS_START);
  localparam logic [9:0] HV_E = 10'(H_VIS_END);
  localparam logic [9:0] VV_S = 10'(V_VIS_START);
  localparam logic [9:0] VV_E = 10'(V_VIS_END);

  logic [15:0] acc;
  logic        vis;

  assign vis = tick && hpos_cur >= HV_S && hpos_cur < HV_E &&
               vline_cur >= VV_S && vline_cur < VV_E;

  // Accumulator restarts at every frame boundary so the first locked report is a whole frame.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= vs_fall && (state == LOCKED);
      if (vs_fall && state == LOCKED)
        frame_sum <= acc;
      if (vs_fall)
        acc <= vis ? {4'd0, rgb_r} : 16'd0;
      else if (vis)
        acc <= acc + {4'd0, rgb_r};
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a shrunken timing so many frames fit in a short run.
module tb_vga_sync_monitor;

  localparam int HT = 20, HP = 3, VT = 12, VP = 2;
  localparam int HVS = 5, HVE = 17, VVS = 3, VVE = 10;
  localparam int PX = 9, PY = 6;

  logic        ClkPort = 1'b0;
  logic        Reset = 1'b1;
  logic        hSync = 1'b1;
  logic        vSync = 1'b1;
  logic [3:0]  vgaR = '0, vgaG = '0, vgaB = '0;
  logic        locked, h_err, v_err, probe_valid;
  logic [15:0] frame_cnt;
  logic [11:0] probe_rgb;
`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        sum_valid;
  logic [15:0] sum_q[$];
`endif

  int          total = 0;
  int          bad = 0;
  logic [11:0] probe_q[$];
  logic        pv_prev = 1'b0;

  always #5 ClkPort = ~ClkPort;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_PULSE(HP), .V_TOTAL(VT), .V_PULSE(VP),
    .H_VIS_START(HVS), .H_VIS_END(HVE), .V_VIS_START(VVS), .V_VIS_END(VVE),
    .PROBE_X(PX), .PROBE_Y(PY)
  ) dut (
    .ClkPort(ClkPort), .Reset(Reset), .hSync(hSync), .vSync(vSync),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .locked(locked), .h_err(h_err), .v_err(v_err), .frame_cnt(frame_cnt),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid)
`ifdef VGA_MON_CHECKSUM_EN
    , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
  );

  // Probe scoreboard: every pulse must match the next expected pixel and last one cycle.
  always @(negedge ClkPort) begin
    if (probe_valid) begin
      total++;
      if (probe_q.size() == 0) begin
        bad++;
        $display("FAIL probe_unexpected got=%h want=none", probe_rgb);
      end else begin
        logic [11:0] exp_rgb;
        exp_rgb = probe_q.pop_front();
        if (probe_rgb !== exp_rgb) begin
          bad++;
          $display("FAIL probe_rgb got=%h want=%h", probe_rgb, exp_rgb);
        end
      end
      total++;
      if (pv_prev !== 1'b0) begin
        bad++;
        $display("FAIL probe_width got=2+ cycles want=1");
      end
    end
    pv_prev = probe_valid;
  end

`ifdef VGA_MON_CHECKSUM_EN
  always @(negedge ClkPort) begin
    if (sum_valid) begin
      total++;
      if (sum_q.size() == 0) begin
        bad++;
        $display("FAIL sum_unexpected got=%h want=none", frame_sum);
      end else begin
        logic [15:0] exp_sum;
        exp_sum = sum_q.pop_front();
        if (frame_sum !== exp_sum) begin
          bad++;
          $display("FAIL frame_sum got=%h want=%h", frame_sum, exp_sum);
        end
      end
    end
  end
`endif

  // One frame of source timing, 4 clk per pixel, syncs aligned to line start.
  // short_line loses its last pixel; the visible-pixel sum is returned for the checksum scoreboard.
  task automatic drive_frame(input int lines, input int short_line, input logic [11:0] probe_color,
                             input bit push_probe, output logic [15:0] fsum);
    fsum = '0;
    for (int l = 0; l < lines; l++) begin
      int len;
      len = (l == short_line) ? 4 * HT - 4 : 4 * HT;
      for (int c = 0; c < len; c++) begin
        int x;
        logic [11:0] pix;
        x = c / 4;
        pix = 12'((l * 37 + x * 11 + 5) % 4096);
        if (l == PY && x == PX) pix = probe_color;
        @(negedge ClkPort);
        hSync = (c < 4 * HP) ? 1'b0 : 1'b1;
        vSync = (l < VP) ? 1'b0 : 1'b1;
        {vgaR, vgaG, vgaB} = pix;
        if (c % 4 == 0 && x >= HVS && x < HVE && l >= VVS && l < VVE)
          fsum = fsum + 16'(pix);
        if (push_probe && c == 4 * PX && l == PY)
          probe_q.push_back(probe_color);
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge ClkPort);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    total++; if (h_err !== 1'b0) begin bad++; $display("FAIL reset_h_err got=%b want=0", h_err); end
    total++; if (v_err !== 1'b0) begin bad++; $display("FAIL reset_v_err got=%b want=0", v_err); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    total++; if (probe_rgb !== 12'h000) begin bad++; $display("FAIL reset_probe_rgb got=%h want=000", probe_rgb); end
    total++; if (probe_valid !== 1'b0) begin bad++; $display("FAIL reset_probe_valid got=%b want=0", probe_valid); end
    Reset = 1'b0;
    repeat (3) @(negedge ClkPort);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL idle_locked got=%b want=0", locked); end
  endtask

  task automatic test_lock;
    logic [15:0] s;
    drive_frame(VT, -1, 12'h123, 1'b0, s);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_f1 got=%b want=0", locked); end
    drive_frame(VT, -1, 12'h123, 1'b0, s);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_f2 got=%b want=0", locked); end
    drive_frame(VT, -1, 12'h456, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_f3 got=%b want=1", locked); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL lock_cnt0 got=%0d want=0", frame_cnt); end
    drive_frame(VT, -1, 12'h789, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_f4 got=%b want=1", locked); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL lock_cnt1 got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_h_err;
    logic [15:0] s;
    drive_frame(VT, 5, 12'hBAD, 1'b0, s);
    total++; if (h_err !== 1'b1) begin bad++; $display("FAIL herr_set got=%b want=1", h_err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL herr_unlock got=%b want=0", locked); end
    total++; if (v_err !== 1'b0) begin bad++; $display("FAIL herr_v_err got=%b want=0", v_err); end
    drive_frame(VT, -1, 12'h111, 1'b0, s);
    drive_frame(VT, -1, 12'h222, 1'b0, s);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL herr_early_lock got=%b want=0", locked); end
    drive_frame(VT, -1, 12'h333, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL herr_relock got=%b want=1", locked); end
    total++; if (h_err !== 1'b1) begin bad++; $display("FAIL herr_sticky got=%b want=1", h_err); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL herr_cnt got=%0d want=2", frame_cnt); end
  endtask

  task automatic test_v_err;
    logic [15:0] s;
    drive_frame(VT - 1, -1, 12'h0F0, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL verr_cnt_pre got=%0d want=3", frame_cnt); end
    drive_frame(VT, -1, 12'h0F0, 1'b0, s);
    total++; if (v_err !== 1'b1) begin bad++; $display("FAIL verr_set got=%b want=1", v_err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL verr_unlock got=%b want=0", locked); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL verr_cnt got=%0d want=3", frame_cnt); end
  endtask

  task automatic test_probe;
    logic [15:0] s;
    drive_frame(VT, -1, 12'hA5C, 1'b0, s);
    drive_frame(VT, -1, 12'hA5C, 1'b0, s);
    drive_frame(VT, -1, 12'hA5C, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL probe_lock got=%b want=1", locked); end
    drive_frame(VT, -1, 12'hA5C, 1'b1, s);
`ifdef VGA_MON_CHECKSUM_EN
    sum_q.push_back(s);
`endif
    total++; if (probe_rgb !== 12'hA5C) begin bad++; $display("FAIL probe_hold got=%h want=a5c", probe_rgb); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s;
    fork
      drive_frame(VT, -1, 12'h321, 1'b0, s);
      begin
        repeat (3 * 4 * HT) @(negedge ClkPort);
        #3 Reset = 1'b1;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%b want=0", locked); end
        total++; if (h_err !== 1'b0) begin bad++; $display("FAIL mid_h_err got=%b want=0", h_err); end
        total++; if (v_err !== 1'b0) begin bad++; $display("FAIL mid_v_err got=%b want=0", v_err); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", frame_cnt); end
        total++; if (probe_rgb !== 12'h000) begin bad++; $display("FAIL mid_probe_rgb got=%h want=000", probe_rgb); end
`ifdef VGA_MON_CHECKSUM_EN
        total++; if (frame_sum !== 16'd0) begin bad++; $display("FAIL mid_frame_sum got=%h want=0", frame_sum); end
`endif
        repeat (4 * HT) @(negedge ClkPort);
        Reset = 1'b0;
      end
    join
    drive_frame(VT, -1, 12'h444, 1'b0, s);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_f1 got=%b want=0", locked); end
    drive_frame(VT, -1, 12'h555, 1'b0, s);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_f2 got=%b want=0", locked); end
    drive_frame(VT, -1, 12'h666, 1'b1, s);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock got=%b want=1", locked); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL mid_relock_cnt got=%0d want=0", frame_cnt); end
    total++; if (h_err !== 1'b0 || v_err !== 1'b0) begin
      bad++; $display("FAIL mid_errs got=%b%b want=00", h_err, v_err);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_h_err();
    test_v_err();
    test_probe();
    test_reset_mid();
    repeat (8) @(negedge ClkPort);
    total++;
    if (probe_q.size() != 0) begin
      bad++;
      $display("FAIL probe_missing got=%0d pending want=0", probe_q.size());
    end
`ifdef VGA_MON_CHECKSUM_EN
    total++;
    if (sum_q.size() != 0) begin
      bad++;
      $display("FAIL sum_missing got=%0d pending want=0", sum_q.size());
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
